// File: rtl/grid_clb_pkg.sv
// -----------------------------------------------------------------------------
// grid_clb_pkg
// Shared definitions for the parametrised logic tile (grid_clb_param) and its
// basic logic element (clb_ble).
//
// Per-BLE configuration field layout, LSB first:
//   [2**K-1:0]      truth table, indexed by the BLE input vector
//   2**K + 0        out_sel (0 = LUT output, 1 = flip-flop)
//   2**K + 1        d_sel   (0 = LUT output, 1 = chain input)
//   2**K + 2        init    (reset value of the ff, only with CLB_FF_INIT_EN)
//
// Optional build macro: CLB_FF_INIT_EN adds the per-BLE init bit.
// -----------------------------------------------------------------------------
package grid_clb_pkg;

  // Truth table starts at bit 0 of every BLE field.
  localparam int LUT_LO = 0;

  // Mode-bit offsets, counted from the first bit above the truth table.
  localparam int OUT_SEL_BIT = 0;
  localparam int D_SEL_BIT   = 1;
`ifdef CLB_FF_INIT_EN
  localparam int INIT_BIT    = 2;
  localparam int MODE_BITS   = 3;
`else
  localparam int MODE_BITS   = 2;
`endif

  // Configuration bits per BLE for a K-input LUT.
  function automatic int ble_cfg_w(input int k);
    return (1 << k) + MODE_BITS;
  endfunction

endpackage

// File: rtl/clb_ble.sv
// -----------------------------------------------------------------------------
// clb_ble
// One basic logic element: a LUT_K-input LUT, a d_sel mux in front of the ff,
// and an out_sel mux choosing the combinational or registered result.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   cfg         this BLE's configuration field (see grid_clb_pkg)
//   lut_in      LUT input vector, bit 0 is the truth-table index LSB
//   chain_in    register-chain input (previous BLE's ff or clb_regin)
//   scan_in     scan-chain input (previous BLE's ff or clb_sc_in)
//   test_en     scan shift has priority over normal operation
//   hold        freezes the ff while configuration is shifting
//   ble_o       selected BLE output
//   ff_q        flip-flop state, feeds the next BLE's chain and scan inputs
// -----------------------------------------------------------------------------
module clb_ble
  import grid_clb_pkg::*;
#(
  parameter int LUT_K = 4,
  parameter int BW    = ble_cfg_w(LUT_K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BW-1:0]    cfg,
  input  logic [LUT_K-1:0] lut_in,
  input  logic             chain_in,
  input  logic             scan_in,
  input  logic             test_en,
  input  logic             hold,
  output logic             ble_o,
  output logic             ff_q
);

  localparam int TT = 1 << LUT_K;

  logic [TT-1:0] truth;
  logic          lut_o;
  logic          out_sel;
  logic          d_sel;
  logic          init_val;

  assign truth   = cfg[LUT_LO +: TT];
  assign lut_o   = truth[lut_in];
  assign out_sel = cfg[TT + OUT_SEL_BIT];
  assign d_sel   = cfg[TT + D_SEL_BIT];
`ifdef CLB_FF_INIT_EN
  assign init_val = cfg[TT + INIT_BIT];
`else
  assign init_val = 1'b0;
`endif

  // Priority: reset, then scan shift, then hold during programming, then load.
  // NOTE: sequential state uses non-blocking assignments so every ff in the
  // chain samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= init_val;
    end else if (test_en) begin
      ff_q <= scan_in;
    end else if (!hold) begin
      ff_q <= d_sel ? chain_in : lut_o;
    end
  end

  assign ble_o = out_sel ? ff_q : lut_o;

endmodule

// File: rtl/grid_clb_param.sv
// -----------------------------------------------------------------------------
// grid_clb_param
// Parametrised logic tile: NUM_BLE basic logic elements fed by a serial
// configuration chain, with the BLE flip-flops also forming a register chain
// and a scan chain.
//
// Parameters: NUM_BLE (BLEs / outputs), LUT_K (LUT inputs per BLE).
// Derived:    BLE_CFG_W (bits per BLE), CFG_BITS (total chain length).
// Optional build macro: CLB_FF_INIT_EN (per-BLE reset value from config).
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Test_en      scan mode
//   prog_en      configuration shift enable
//   ccff_head    configuration serial in
//   ccff_tail    configuration serial out (registered, CFG_BITS cycles)
//   clb_I        BLE inputs, BLE i uses clb_I[i*LUT_K +: LUT_K]
//   clb_regin    register-chain input into BLE0
//   clb_regout   register-chain output, ff of the last BLE
//   clb_sc_in    scan in
//   clb_sc_out   scan out, ff of the last BLE
//   clb_O        BLE outputs
// -----------------------------------------------------------------------------
module grid_clb_param
  import grid_clb_pkg::*;
#(
  parameter int NUM_BLE = 8,
  parameter int LUT_K   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Test_en,
  input  logic                     prog_en,
  input  logic                     ccff_head,
  output logic                     ccff_tail,
  input  logic [NUM_BLE*LUT_K-1:0] clb_I,
  input  logic                     clb_regin,
  output logic                     clb_regout,
  input  logic                     clb_sc_in,
  output logic                     clb_sc_out,
  output logic [NUM_BLE-1:0]       clb_O
);

  localparam int BLE_CFG_W = ble_cfg_w(LUT_K);
  localparam int CFG_BITS  = NUM_BLE * BLE_CFG_W;

  logic [CFG_BITS-1:0] cfg;
  logic [NUM_BLE-1:0]  ff_q;
  logic [NUM_BLE-1:0]  chain_vec;
  logic [NUM_BLE-1:0]  scan_vec;

  // NOTE: the configuration store has no reset term on purpose; a reset only
  // pauses the shift so a partially loaded bitstream survives it.
  always_ff @(posedge clk) begin
    if (!reset && prog_en) begin
      cfg <= {cfg[CFG_BITS-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CFG_BITS-1];

  // Element i of each vector is the chain / scan input of BLE i.
  assign chain_vec = {ff_q[NUM_BLE-2:0], clb_regin};
  assign scan_vec  = {ff_q[NUM_BLE-2:0], clb_sc_in};

  for (genvar i = 0; i < NUM_BLE; i++) begin : g_ble
    clb_ble #(
      .LUT_K (LUT_K),
      .BW    (BLE_CFG_W)
    ) u_ble (
      .clk      (clk),
      .reset    (reset),
      .cfg      (cfg[i*BLE_CFG_W +: BLE_CFG_W]),
      .lut_in   (clb_I[i*LUT_K +: LUT_K]),
      .chain_in (chain_vec[i]),
      .scan_in  (scan_vec[i]),
      .test_en  (Test_en),
      .hold     (prog_en),
      .ble_o    (clb_O[i]),
      .ff_q     (ff_q[i])
    );
  end

  assign clb_regout = ff_q[NUM_BLE-1];
  assign clb_sc_out = ff_q[NUM_BLE-1];

endmodule

// File: tb/tb_grid_clb_param.sv
// -----------------------------------------------------------------------------
// tb_grid_clb_param
// Directed self-checking bench for grid_clb_param (NUM_BLE=8, LUT_K=4).
// Honours CLB_FF_INIT_EN for the config image layout and expected reset values.
// -----------------------------------------------------------------------------
module tb_grid_clb_param;

  localparam int N  = 8;
  localparam int K  = 4;
`ifdef CLB_FF_INIT_EN
  localparam int BW = 19;
`else
  localparam int BW = 18;
`endif
  localparam int CFG = N * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic           Test_en;
  logic           prog_en;
  logic           ccff_head;
  logic           ccff_tail;
  logic [N*K-1:0] clb_I;
  logic           clb_regin;
  logic           clb_regout;
  logic           clb_sc_in;
  logic           clb_sc_out;
  logic [N-1:0]   clb_O;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CFG-1:0] img;

  grid_clb_param #(.NUM_BLE(N), .LUT_K(K)) dut (
    .clk        (clk),
    .reset      (reset),
    .Test_en    (Test_en),
    .prog_en    (prog_en),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .clb_I      (clb_I),
    .clb_regin  (clb_regin),
    .clb_regout (clb_regout),
    .clb_sc_in  (clb_sc_in),
    .clb_sc_out (clb_sc_out),
    .clb_O      (clb_O)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change here, outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ble(input int i, input logic [15:0] tt, input logic osel,
                         input logic dsel, input logic init);
    img[i*BW +: 16] = tt;
    img[i*BW + 16]  = osel;
    img[i*BW + 17]  = dsel;
`ifdef CLB_FF_INIT_EN
    img[i*BW + 18]  = init;
`else
    if (init) img[i*BW] = img[i*BW]; // init bit has no slot in this build
`endif
  endtask

  // Shift img MSB first so that cfg equals img after CFG edges.
  task automatic load_cfg();
    prog_en = 1'b1;
    for (int j = CFG - 1; j >= 0; j--) begin
      ccff_head = img[j];
      tick();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  logic exp_ff7;

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    img = '0;
    img[CFG-1] = 1'b1;  // d_sel of BLE7, or its init bit with CLB_FF_INIT_EN
`ifdef CLB_FF_INIT_EN
    exp_ff7 = 1'b1;
`else
    exp_ff7 = 1'b0;
`endif
    load_cfg();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (ccff_tail !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_tail cyc%0d: got %b want 1", c, ccff_tail);
      end
      n_tests++;
      if (clb_regout !== exp_ff7 || clb_sc_out !== exp_ff7) begin
        n_fail++;
        $display("FAIL reset_ff7 cyc%0d: regout %b sc_out %b want %b", c, clb_regout, clb_sc_out, exp_ff7);
      end
      n_tests++;
      if (clb_O !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_clb_O cyc%0d: got %h want 00", c, clb_O);
      end
    end
    reset = 1'b0;
  endtask

  // Random load, zero flush; a 3-cycle reset in the middle must lose nothing.
  task automatic test_cfg_loopback();
    logic [CFG-1:0] bits;
    logic           ff_known;
    int             idx;
    for (int j = 0; j < CFG; j++) bits[j] = 1'($urandom);
    ff_known = 1'b1;
    prog_en  = 1'b1;
    for (int s = 0; s < 2 * CFG - 1; s++) begin
      if (s == 50) begin
        ccff_head = ~bits[s];
        reset     = 1'b1;
        repeat (3) tick();
        reset     = 1'b0;
`ifdef CLB_FF_INIT_EN
        ff_known  = 1'b0;  // init bits now come from a partial bitstream
`endif
      end
      ccff_head = (s < CFG) ? bits[s] : 1'b0;
      tick();
      idx = s + 1 - CFG;
      if (idx >= 0) begin
        n_tests++;
        if (ccff_tail !== bits[idx]) begin
          n_fail++;
          $display("FAIL loopback_tail bit%0d: got %b want %b", idx, ccff_tail, bits[idx]);
        end
      end
      if (ff_known && (s % 16 == 0)) begin
        n_tests++;
        if (clb_regout !== exp_ff7) begin
          n_fail++;
          $display("FAIL loopback_ff_hold s%0d: got %b want %b", s, clb_regout, exp_ff7);
        end
      end
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic test_comb_lut();
    img = '0;
    set_ble(0, 16'h8000, 1'b0, 1'b0, 1'b0);  // AND4
    set_ble(1, 16'h0001, 1'b0, 1'b0, 1'b0);  // NOR4
    load_cfg();
    clb_I = '0;
    clb_I[3:0] = 4'hF;
    clb_I[7:4] = 4'h0;
    #1;
    n_tests++;
    if (clb_O[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL comb_and_nor_true: got %b want 11", clb_O[1:0]);
    end
    clb_I[3:0] = 4'hE;
    clb_I[7:4] = 4'h2;
    #1;
    n_tests++;
    if (clb_O[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL comb_and_nor_false: got %b want 00", clb_O[1:0]);
    end
    clb_I = '0;
  endtask

  task automatic test_reg_xor();
    img = '0;
    set_ble(0, 16'h6996, 1'b1, 1'b0, 1'b0);  // registered XOR4
    load_cfg();
    clb_I = '0;
    pulse_reset();
    n_tests++;
    if (clb_O[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_after_reset: got %b want 0", clb_O[0]);
    end
    clb_I[3:0] = 4'h1;
    #1;
    n_tests++;
    if (clb_O[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_no_same_cycle: got %b want 0", clb_O[0]);
    end
    tick();
    n_tests++;
    if (clb_O[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL xor_one_edge: got %b want 1", clb_O[0]);
    end
    clb_I[3:0] = 4'h3;
    tick();
    n_tests++;
    if (clb_O[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_in3: got %b want 0", clb_O[0]);
    end
    clb_I[3:0] = 4'h7;
    tick();
    n_tests++;
    if (clb_O[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL xor_in7: got %b want 1", clb_O[0]);
    end
    pulse_reset();
    n_tests++;
    if (clb_O[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_reset_clears: got %b want 0", clb_O[0]);
    end
    clb_I = '0;
  endtask

  task automatic test_reg_chain();
    logic [N-1:0] exp_o;
    img = '0;
    for (int i = 0; i < N; i++) set_ble(i, 16'h0000, 1'b1, 1'b1, 1'b0);
    load_cfg();
    pulse_reset();
    clb_regin = 1'b1;
    for (int e = 1; e <= N + 1; e++) begin
      tick();
      clb_regin = 1'b0;
      exp_o = (e <= N) ? N'(1) << (e - 1) : '0;
      n_tests++;
      if (clb_O !== exp_o || clb_regout !== (e == N)) begin
        n_fail++;
        $display("FAIL chain_edge%0d: clb_O %h regout %b want %h %b", e, clb_O, clb_regout, exp_o, e == N);
      end
    end
  endtask

  // Relies on the chain configuration (out_sel=1) left by test_reg_chain.
  task automatic test_scan();
    logic [7:0] pat;
    pat = 8'hA5;
    pulse_reset();
    Test_en = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      clb_sc_in = (e <= 8) ? pat[e-1] : 1'b0;
      tick();
      if (e == 8) begin
        n_tests++;
        if (clb_O !== 8'hA5) begin
          n_fail++;
          $display("FAIL scan_full_load: got %h want a5", clb_O);
        end
      end
      if (e >= 8) begin
        n_tests++;
        if (clb_sc_out !== pat[e-8]) begin
          n_fail++;
          $display("FAIL scan_out edge%0d: got %b want %b", e, clb_sc_out, pat[e-8]);
        end
      end
    end
    // Reset in the middle of a scan shift clears the ffs.
    for (int e = 1; e <= 4; e++) begin
      clb_sc_in = pat[e-1];
      tick();
    end
    n_tests++;
    if (clb_O !== 8'h0A) begin
      n_fail++;
      $display("FAIL scan_partial: got %h want 0a", clb_O);
    end
    clb_sc_in = 1'b1;
    pulse_reset();
    n_tests++;
    if (clb_O !== 8'h00) begin
      n_fail++;
      $display("FAIL scan_mid_reset: got %h want 00", clb_O);
    end
    Test_en   = 1'b0;
    clb_sc_in = 1'b0;
  endtask

  task automatic test_ff_init();
    logic [7:0] init_pat;
    logic [7:0] exp_o;
    init_pat = 8'h3C;
    img = '0;
    for (int i = 0; i < N; i++) set_ble(i, 16'h0000, 1'b1, 1'b0, init_pat[i]);
    load_cfg();
`ifdef CLB_FF_INIT_EN
    exp_o = 8'h3C;
`else
    exp_o = 8'h00;
`endif
    pulse_reset();
    n_tests++;
    if (clb_O !== exp_o) begin
      n_fail++;
      $display("FAIL init_reset_value: got %h want %h", clb_O, exp_o);
    end
    tick();
    n_tests++;
    if (clb_O !== 8'h00) begin
      n_fail++;
      $display("FAIL init_then_lut: got %h want 00", clb_O);
    end
  endtask

  initial begin
    reset     = 1'b0;
    Test_en   = 1'b0;
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    clb_I     = '0;
    clb_regin = 1'b0;
    clb_sc_in = 1'b0;
    img       = '0;
    exp_ff7   = 1'b0;
    #2;
    test_reset();
    test_cfg_loopback();
    test_comb_lut();
    test_reg_xor();
    test_reg_chain();
    test_scan();
    test_ff_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
